spi_slave_frame_engine: RTL

SPI_SLAVE_FRAME_ENGINE -- requirements
Module: spi_slave_frame_engine

---
 rtl/spi_slave_frame_engine.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_frame_engine.sv
// SPI mode-0 slave frame engine: {rw, addr} command byte then one data word,
// with write-word and read-fetch handshakes. Define SPI_SDIO_3WIRE_EN for 3-wire sdo_oe.
module spi_slave_frame_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  scl,
  input  logic                  cs_n,
  input  logic                  sdi,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_err
);

  // state | meaning
  // IDLE  | waiting for a qualified cs_n falling edge
  // CMD   | shifting in the {rw, addr} command byte
  // WDATA | shifting in the write data word
  // RDATA | shifting out the fetched read word
  // DONE  | word complete, further bits ignored until cs_n rises
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  localparam int CNT_MAX = (DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1;
  localparam int CW      = $clog2(CNT_MAX);

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  scl_sync, cs_sync, sdi_sync;
  logic                    scl_d, cs_d;
  logic [1:0]              flush_cnt;
  logic                    armed;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg, out_sh;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_wait, rd_got, first_fall, sdo_q;
  logic                    cmd_done, word_done, abort;

  wire scl_s    = scl_sync[SYNC_STAGES-1];
  wire cs_s     = cs_sync[SYNC_STAGES-1];
  wire sdi_s    = sdi_sync[SYNC_STAGES-1];
  wire scl_rise = scl_s & ~scl_d;
  wire scl_fall = ~scl_s & scl_d;
  wire cs_rise  = cs_s & ~cs_d;
  wire cs_fall  = ~cs_s & cs_d;
  wire bit_last = (bit_cnt == '0);

  wire [ADDR_WIDTH:0]     cmd_word = {shreg[ADDR_WIDTH-1:0], sdi_s};
  wire [DATA_WIDTH-1:0]   in_word  = {shreg[DATA_WIDTH-2:0], sdi_s};

  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE:  if (cs_fall && armed) state_nxt = CMD;
      CMD: begin
        if (cs_rise) abort = 1'b1;
        else if (scl_rise && bit_last) begin
          cmd_done  = 1'b1;
          state_nxt = cmd_word[ADDR_WIDTH] ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (cs_rise) abort = 1'b1;
        else if (scl_rise && bit_last) begin
          word_done = 1'b1;
          state_nxt = DONE;
        end
      end
      RDATA: begin
        if (cs_rise) abort = 1'b1;
        else if (scl_rise && bit_last) state_nxt = DONE;
      end
      DONE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      scl_sync   <= '0;
      cs_sync    <= '1;
      sdi_sync   <= '0;
      scl_d      <= 1'b0;
      cs_d       <= 1'b1;
      flush_cnt  <= 2'(SYNC_STAGES);
      armed      <= 1'b0;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      out_sh     <= '0;
      addr_q     <= '0;
      rd_wait    <= 1'b0;
      rd_got     <= 1'b0;
      first_fall <= 1'b0;
      sdo_q      <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      frame_err  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      scl_d     <= scl_s;
      cs_d      <= cs_s;
      state     <= state_nxt;
      rd_req    <= cmd_done & cmd_word[ADDR_WIDTH];
      frame_err <= abort;

      // The chain holds reset values until flushed; only then may cs_n high arm framing,
      // so a chip select already low at reset release never starts a frame.
      if (flush_cnt != 2'd0) flush_cnt <= flush_cnt - 2'd1;
      else if (cs_s)         armed     <= 1'b1;

      if (state == IDLE && state_nxt == CMD) begin
        bit_cnt    <= CW'(ADDR_WIDTH);
        rd_wait    <= 1'b0;
        rd_got     <= 1'b0;
        first_fall <= 1'b1;
      end

      if (scl_rise && !abort && (state == CMD || state == WDATA || state == RDATA)) begin
        shreg <= in_word;
        if (!bit_last) bit_cnt <= bit_cnt - CW'(1);
      end

      if (cmd_done) begin
        bit_cnt <= CW'(DATA_WIDTH - 1);
        addr_q  <= cmd_word[ADDR_WIDTH-1:0];
        if (cmd_word[ADDR_WIDTH]) begin
          rd_addr <= cmd_word[ADDR_WIDTH-1:0];
          rd_wait <= 1'b1;
        end
      end

      if (rd_wait && rd_ack) begin
        out_sh  <= rd_data;
        rd_got  <= 1'b1;
        rd_wait <= 1'b0;
      end

      if (abort) rd_wait <= 1'b0;

      // The first falling edge in RDATA decides the frame: real word or all zeros.
      if (state == RDATA && scl_fall && !abort) begin
        first_fall <= 1'b0;
        if (first_fall && !rd_got) begin
          sdo_q     <= 1'b0;
          out_sh    <= '0;
          rd_wait   <= 1'b0;
          frame_err <= 1'b1;
        end else begin
          sdo_q  <= out_sh[DATA_WIDTH-1];
          out_sh <= {out_sh[DATA_WIDTH-2:0], 1'b0};
        end
      end

      if (wr_valid && wr_ready) wr_valid <= 1'b0;
      if (word_done) begin
        if (wr_valid && !wr_ready) begin
          frame_err <= 1'b1;
        end else begin
          wr_valid <= 1'b1;
          wr_addr  <= addr_q;
          wr_data  <= in_word;
        end
      end
    end
  end

  assign sdo = (state == RDATA) & sdo_q;

`ifdef SPI_SDIO_3WIRE_EN
  assign sdo_oe = (state == RDATA);
`else
  assign sdo_oe = ~cs_s;
`endif

endmodule
